// File: rtl/mem_wb_stage.sv
// Memory-access/writeback stage: one instruction in flight, load/store over a req/ack bus, result to the register file.
// Latency: ALU op 2 cycles (accept, WB); memory op accept + REQ (>=1) + WB. ex_ready is high only in IDLE; the bus holds mem_req until ack or timeout.
module mem_wb_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_sdata,
    input  logic [4:0]  ex_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  write_num,
    output logic [31:0] write_res,
    output logic        misalign,
    output logic        bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WB} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_is_load;
    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_sdata;
    logic [4:0]  r_rd;
    logic [4:0]  r_dest;
    logic [31:0] r_result;
    logic [15:0] r_cnt;
    logic        r_misalign;
    logic        r_bus_err;

    logic        w_accept;
    logic        w_ex_mem;
    logic        w_ex_mis;
    logic        w_timeout;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;

    assign w_accept  = (r_state == S_IDLE) && ex_valid;
    assign w_ex_mem  = ex_is_load || ex_is_store;
    // funct3[1:0]: 00 byte, 01 half, 1x word
    assign w_ex_mis  = w_ex_mem &&
                       (((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                        (ex_funct3[1] && (ex_addr[1:0] != 2'b00)));
    assign w_timeout = (r_state == S_REQ) && !mem_ack && (r_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (ex_valid) begin
                    w_next = (w_ex_mem && !w_ex_mis) ? S_REQ : S_WB;
                end
            end
            S_REQ: begin
                if (mem_ack || w_timeout) begin
                    w_next = S_WB;
                end
            end
            S_WB:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_byte = 8'h00;
        case (r_addr[1:0])
            2'b00: w_byte = mem_rdata[7:0];
            2'b01: w_byte = mem_rdata[15:8];
            2'b10: w_byte = mem_rdata[23:16];
            2'b11: w_byte = mem_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3[1:0])
            2'b00:   w_load = {{24{w_byte[7] && !r_funct3[2]}}, w_byte};
            2'b01:   w_load = {{16{w_half[15] && !r_funct3[2]}}, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    always_comb begin
        case (r_funct3[1:0])
            2'b00: begin
                w_wdata = {4{r_sdata[7:0]}};
                w_wstrb = 4'b0001 << r_addr[1:0];
            end
            2'b01: begin
                w_wdata = {2{r_sdata[15:0]}};
                w_wstrb = r_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_wdata = r_sdata;
                w_wstrb = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_load  <= 1'b0;
            r_is_store <= 1'b0;
            r_funct3   <= 3'b000;
            r_addr     <= 32'h0;
            r_sdata    <= 32'h0;
            r_rd       <= 5'd0;
            r_dest     <= 5'd0;
            r_result   <= 32'h0;
            r_cnt      <= 16'h0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                // load wins when execute flags both load and store
                r_is_load  <= ex_is_load;
                r_is_store <= ex_is_store && !ex_is_load;
                r_funct3   <= ex_funct3;
                r_addr     <= ex_addr;
                r_sdata    <= ex_sdata;
                r_rd       <= ex_rd;
                r_cnt      <= 16'h0;
                if (!w_ex_mem) begin
                    r_dest   <= ex_rd;
                    r_result <= ex_addr;
                end else begin
                    r_dest   <= 5'd0;
                    r_result <= 32'h0;
                    if (w_ex_mis) begin
                        r_misalign <= 1'b1;
                    end
                end
            end
            if (r_state == S_REQ) begin
                if (mem_ack) begin
                    r_cnt <= 16'h0;
                    if (r_is_load) begin
                        r_dest   <= r_rd;
                        r_result <= w_load;
                    end else begin
                        r_dest <= 5'd0;
                    end
                end else if (w_timeout) begin
                    r_cnt     <= 16'h0;
                    r_bus_err <= 1'b1;
                    r_dest    <= 5'd0;
                end else begin
                    r_cnt <= r_cnt + 16'h1;
                end
            end
        end
    end

    always_comb begin
        ex_ready  = (r_state == S_IDLE);
        mem_req   = (r_state == S_REQ);
        mem_we    = mem_req && r_is_store;
        mem_addr  = mem_req ? {r_addr[31:2], 2'b00} : 32'h0;
        mem_wdata = mem_req ? w_wdata : 32'h0;
        mem_wstrb = (mem_req && r_is_store) ? w_wstrb : 4'b0000;
        write_num = (r_state == S_WB) ? r_dest : 5'd0;
        write_res = ((r_state == S_WB) && (r_dest != 5'd0)) ? r_result : 32'h0;
        misalign  = r_misalign;
        bus_err   = r_bus_err;
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage: transaction-level model drives per-cycle expectations
// checked every cycle, plus hand-computed literal checks on directed cases.
module tb_mem_wb_stage;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic        ex_is_load = 1'b0;
    logic        ex_is_store = 1'b0;
    logic [2:0]  ex_funct3 = 3'b0;
    logic [31:0] ex_addr = 32'h0;
    logic [31:0] ex_sdata = 32'h0;
    logic [4:0]  ex_rd = 5'd0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [4:0]  write_num;
    logic [31:0] write_res;
    logic        misalign;
    logic        bus_err;

    mem_wb_stage #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_sdata(ex_sdata), .ex_rd(ex_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .write_num(write_num), .write_res(write_res),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    bit          chk_en = 1'b0;
    logic        exp_ready, exp_req, exp_we, exp_mis, exp_err;
    logic [31:0] exp_addr, exp_wdata, exp_res;
    logic [3:0]  exp_wstrb;
    logic [4:0]  exp_num;
    bit          exp_chk_wdata;

    logic        rec_req_seen, rec_we;
    logic [31:0] rec_addr, rec_wdata, rec_res;
    logic [3:0]  rec_wstrb;
    logic [4:0]  rec_num;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ex_ready",  32'(ex_ready),  32'(exp_ready));
            chk("mem_req",   32'(mem_req),   32'(exp_req));
            chk("mem_we",    32'(mem_we),    32'(exp_we));
            chk("mem_addr",  mem_addr,       exp_addr);
            chk("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
            if (exp_chk_wdata) chk("mem_wdata", mem_wdata, exp_wdata);
            chk("write_num", 32'(write_num), 32'(exp_num));
            chk("write_res", write_res,      exp_res);
            chk("misalign",  32'(misalign),  32'(exp_mis));
            chk("bus_err",   32'(bus_err),   32'(exp_err));
        end
    end

    function automatic int unsigned sz_of(input logic [2:0] f3);
        return f3[1] ? 4 : (f3[0] ? 2 : 1);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int unsigned sz = sz_of(f3);
        logic [31:0] v;
        if (sz == 4) return rdata;
        v = rdata >> ((addr % 4) * 8);
        if (sz == 1) begin
            v = v & 32'hFF;
            if (!f3[2] && v >= 32'h80) v = v - 32'h100;
        end else begin
            v = v & 32'hFFFF;
            if (!f3[2] && v >= 32'h8000) v = v - 32'h10000;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sdata);
        int unsigned sz = sz_of(f3);
        if (sz == 1) return (sdata & 32'hFF) * 32'h01010101;
        if (sz == 2) return (sdata & 32'hFFFF) * 32'h00010001;
        return sdata;
    endfunction

    function automatic logic [3:0] model_wstrb(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned sz = sz_of(f3);
        return 4'(((1 << sz) - 1) << (addr % 4));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        exp_ready = 1; exp_req = 0; exp_we = 0; exp_addr = 0;
        exp_wdata = 0; exp_chk_wdata = 1; exp_wstrb = 0; exp_num = 0; exp_res = 0;
    endtask

    task automatic run_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [4:0] rd, input int dly,
                          input logic [31:0] rdata);
        bit is_ld, is_st, mem, mis, acked;
        logic [4:0]  dest;
        logic [31:0] res;
        is_ld = ld;
        is_st = st && !ld;
        mem   = ld || st;
        mis   = mem && ((addr % sz_of(f3)) != 0);
        acked = 0;
        rec_req_seen = 0;
        set_idle();
        ex_valid = 1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
        ex_addr = addr; ex_sdata = sdata; ex_rd = rd;
        tick();
        if (mem && !mis) begin
            for (int k = 0; k < TMO; k++) begin
                ex_valid = 1'($urandom); ex_addr = $urandom; ex_rd = 5'($urandom);
                exp_ready = 0; exp_req = 1; exp_we = is_st; exp_addr = addr & ~32'h3;
                exp_chk_wdata = is_st; exp_wdata = model_wdata(f3, sdata);
                exp_wstrb = is_st ? model_wstrb(f3, addr) : 4'b0000;
                exp_num = 0; exp_res = 0;
                mem_ack   = (k == dly);
                mem_rdata = (k == dly) ? rdata : $urandom;
                @(negedge clk);
                rec_req_seen = rec_req_seen | mem_req;
                rec_we = mem_we; rec_addr = mem_addr; rec_wdata = mem_wdata; rec_wstrb = mem_wstrb;
                tick();
                mem_ack = 0;
                if (k == dly) begin
                    acked = 1;
                    break;
                end
            end
            if (!acked) exp_err = 1;
        end
        if (mis) exp_mis = 1;
        if (!mem) begin
            dest = rd; res = addr;
        end else if (is_ld && acked) begin
            dest = rd; res = model_load(f3, addr, rdata);
        end else begin
            dest = 0; res = 0;
        end
        if (dest == 0) res = 0;
        set_idle();
        exp_ready = 0; exp_num = dest; exp_res = res;
        ex_valid = 1'($urandom); ex_addr = $urandom; ex_rd = 5'($urandom);
        mem_ack = 1'($urandom); mem_rdata = $urandom;
        @(negedge clk);
        rec_req_seen = rec_req_seen | mem_req;
        rec_num = write_num; rec_res = write_res;
        tick();
        ex_valid = 0; mem_ack = 0;
        set_idle();
    endtask

    initial begin
        set_idle();
        exp_mis = 0; exp_err = 0;
        #3;
        chk("rst_ready",   32'(ex_ready),  32'd1);
        chk("rst_req",     32'(mem_req),   32'd0);
        chk("rst_num",     32'(write_num), 32'd0);
        chk("rst_flags",   32'({misalign, bus_err}), 32'd0);
        #9 rst = 0;
        tick();
        chk_en = 1;

        run_op(0, 0, 3'b000, 32'h1234_5678, 32'h0, 5'd5, 0, 32'h0);
        chk("alu_num", 32'(rec_num), 32'd5);
        chk("alu_res", rec_res, 32'h1234_5678);
        chk("alu_noreq", 32'(rec_req_seen), 32'd0);

        run_op(1, 0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 2, 32'h80FF_0000);
        chk("lb_addr", rec_addr, 32'h0000_0100);
        chk("lb_res",  rec_res,  32'hFFFF_FF80);
        run_op(1, 0, 3'b100, 32'h0000_0103, 32'h0, 5'd7, 2, 32'h80FF_0000);
        chk("lbu_res", rec_res,  32'h0000_0080);
        run_op(1, 0, 3'b001, 32'h0000_0202, 32'h0, 5'd9, 0, 32'h8001_1234);
        chk("lh_res",  rec_res,  32'hFFFF_8001);
        run_op(1, 0, 3'b101, 32'h0000_0202, 32'h0, 5'd9, 1, 32'h8001_1234);
        chk("lhu_res", rec_res,  32'h0000_8001);

        run_op(0, 1, 3'b000, 32'h0000_0041, 32'h0000_00AB, 5'd3, 1, 32'h0);
        chk("sb_we",    32'(rec_we),    32'd1);
        chk("sb_wstrb", 32'(rec_wstrb), 32'b0010);
        chk("sb_wdata", rec_wdata,      32'hABAB_ABAB);
        chk("sb_num",   32'(rec_num),   32'd0);

        run_op(0, 1, 3'b010, 32'h0000_0042, 32'hDEAD_BEEF, 5'd4, 0, 32'h0);
        chk("sw_mis",    32'(misalign),     32'd1);
        chk("sw_noreq",  32'(rec_req_seen), 32'd0);
        chk("sw_num",    32'(rec_num),      32'd0);
        chk("sw_ready",  32'(ex_ready),     32'd1);

        run_op(1, 0, 3'b010, 32'h0000_0300, 32'h0, 5'd6, TMO + 1, 32'h0);
        chk("tmo_err", 32'(bus_err), 32'd1);
        chk("tmo_num", 32'(rec_num), 32'd0);

        for (int n = 0; n < 300; n++) begin
            int unsigned cls;
            logic [2:0]  f3;
            logic [31:0] a;
            cls = $urandom % 4;
            a   = $urandom;
            if (cls == 0)      f3 = 3'($urandom);
            else if (cls == 2) f3 = 3'($urandom % 3);
            else begin
                case ($urandom % 5)
                    0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end
            if ($urandom % 2 == 1) a = a & ~32'h3;
            run_op(cls[0], cls[1], f3, a, $urandom, 5'($urandom), int'($urandom_range(0, 5)), $urandom);
            if ($urandom % 3 == 0) begin
                mem_ack = 1'($urandom); mem_rdata = $urandom;
                tick();
                mem_ack = 0;
            end
        end

        chk_en = 0;
        ex_valid = 1; ex_is_load = 1; ex_is_store = 0; ex_funct3 = 3'b010;
        ex_addr = 32'h0000_0400; ex_rd = 5'd8;
        tick();
        ex_valid = 0;
        @(negedge clk);
        chk("rreq_active", 32'(mem_req), 32'd1);
        #2 rst = 1;
        #1;
        chk("rreq_drop",   32'(mem_req),   32'd0);
        chk("rreq_ready",  32'(ex_ready),  32'd1);
        chk("rreq_addr",   mem_addr,       32'h0);
        chk("rreq_flags",  32'({misalign, bus_err}), 32'd0);
        @(negedge clk);
        rst = 0;
        tick();
        chk("rrel_ready",  32'(ex_ready),  32'd1);
        chk("rrel_req",    32'(mem_req),   32'd0);
        chk("rrel_flags",  32'({misalign, bus_err}), 32'd0);
        exp_mis = 0; exp_err = 0;
        set_idle();
        chk_en = 1;
        run_op(0, 0, 3'b000, 32'hCAFE_F00D, 32'h0, 5'd31, 0, 32'h0);
        chk("post_rst_res", rec_res, 32'hCAFE_F00D);
        chk_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access and writeback stage of the Scipio core. Sits between execute and the register file.
- Accepts one instruction at a time from execute and performs the data-memory load or store over a req/ack bus.
- Aligns and sign-extends load data, then drives the register file's write_num/write_res pair.
- Writing register 0 is the register file's "no write" encoding. This block drives write_num=0, write_res=0 whenever no write is pending.

Parameters:
TIMEOUT, 255, max cycles waiting for mem_ack before flagging bus_err (1..65535)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset
ex_valid  in  1  execute presents an instruction
ex_ready  out  1  stage can accept (high only in IDLE)
ex_is_load  in  1  instruction is LB/LH/LW/LBU/LHU
ex_is_store  in  1  instruction is SB/SH/SW
ex_funct3  in  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
ex_addr  in  32  effective address (memory ops) or ALU result (others)
ex_sdata  in  32  store data (rs2 value)
ex_rd  in  5  destination register
mem_req  out  1  memory request
mem_we  out  1  1=store
mem_addr  out  32  word address, low 2 bits forced 0
mem_wdata  out  32  store data replicated into lanes
mem_wstrb  out  4  byte enables
mem_ack  in  1  memory completes request (1-cycle pulse)
mem_rdata  in  32  load word, valid with mem_ack
write_num  out  5  to register file write_num
write_res  out  32  to register file write_res
misalign  out  1  sticky: misaligned access seen
bus_err  out  1  sticky: mem_ack timeout

Behaviour:
- Reset is rst, asynchronous, active-high. While asserted, all outputs are 0 except ex_ready, and state is IDLE. Sticky flags, the timeout counter and all captured fields are cleared.
- State IDLE:
  - ex_ready=1. A transfer occurs on a clock edge with ex_valid=1.
  - All ex_* fields are captured into registers.
  - Neither load nor store (both 0): go to WB with result=ex_addr and dest=ex_rd.
  - ex_is_load and ex_is_store both 1: treated as load.
  - Load/store, aligned: go to REQ.
- Misalignment:
  - H with addr[0]=1, or W with addr[1:0]!=0, is misaligned.
  - Set misalign. No bus request. Go to WB with dest=0, i.e. no write.
- State REQ:
  - mem_req=1. mem_we, mem_addr={addr[31:2],2'b00}, mem_wdata and mem_wstrb are held stable until ack.
  - Store lanes:
    - SB: wdata={4{sdata[7:0]}}, wstrb=1<<addr[1:0].
    - SH: wdata={2{sdata[15:0]}}, wstrb=addr[1]?1100:0011.
    - SW: wdata=sdata, wstrb=1111.
  - Loads: wstrb=0000.
  - Timeout counter increments each cycle in REQ.
  - mem_ack=1: deassert mem_req next cycle and clear the counter.
    - Load: capture the aligned and extended value, dest=rd, go to WB.
    - Store: dest=0, go to WB.
  - Counter reaches TIMEOUT without ack: set bus_err, dest=0, go to WB.
  - mem_ack in any state other than REQ is ignored.
- Load extraction from mem_rdata:
  - Byte lane selected by addr[1:0]; halfword lane by addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- State WB:
  - Exactly one cycle. write_num=dest, write_res=result (result forced 0 when dest=0).
  - ex_ready=0. Next state IDLE.
- Outside WB, write_num=0 and write_res=0.
- Non-memory op latency: accept edge, then WB the next cycle, then IDLE. One instruction per 2 cycles.
- Memory op latency: accept, REQ (>=1 cycle), WB.
- Destination rd=0 is passed through as 0. A load to x0 still performs the bus read.
- Reset mid-REQ: mem_req drops immediately (asynchronous); the transaction is abandoned. The memory side tolerates a dropped request.
- Sticky flags clear only on rst.

Test Plan:
- ALU op: ex_valid, ex_addr=0x1234_5678, rd=5 -> one cycle later write_num=5, write_res=0x12345678 for exactly 1 cycle; mem_req stays 0.
- LB sign/LBU zero:
  - LB addr=0x103, mem_rdata=0x80FF_0000, ack after 3 cycles -> mem_addr=0x100; write_res=0xFFFFFF80.
  - Same with LBU -> write_res=0x00000080.
- LH at addr 0x202, mem_rdata=0x8001_1234 -> write_res=0xFFFF8001. LHU -> 0x00008001.
- SB addr=0x41, sdata=0xAB -> mem_we=1, mem_wstrb=0010, mem_wdata=0xABABABAB; WB cycle has write_num=0.
- SW addr=0x42 -> misalign=1, mem_req never asserts, write_num stays 0, ex_ready returns after 2 cycles.
- Timeout and reset:
  - TIMEOUT=4, load with no ack -> bus_err=1 after 4 REQ cycles, no register write.
  - Separately, rst asserted during REQ -> mem_req=0 same cycle; IDLE with flags clear after release.
